// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl: cache line-fill controller with several memory reads in flight.
// On a miss it reads LINE_WORDS words, with up to MAX_OUT reads outstanding.
// The words come back sequentially from word 0, or critical-word-first with wrap
// when CWF=1. After the last word it writes the tag.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   miss_detected, miss_address  miss request; sampled only in IDLE
//   fsm_busy                     fill in progress (also high in the accepting miss cycle)
//   mem_req_valid/ready/address  memory read request channel (word-aligned address)
//   mem_data, mem_data_valid     in-order read responses
//   wen_data, data_word_idx, data_out  data-array write port
//   crit_word_ready              pulse when the missed word is written
//   wen_tag, tag_out, fill_done  tag-array write; fill_done pulses with wen_tag
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned WORD_W     = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned MAX_OUT    = 2,
  parameter int unsigned CWF        = 0,
  localparam int unsigned BO        = $clog2(WORD_W / 8),
  localparam int unsigned IW        = $clog2(LINE_WORDS),
  localparam int unsigned OFS       = BO + IW,
  localparam int unsigned TAG_W     = ADDR_W - OFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  output logic              fsm_busy,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [WORD_W-1:0] mem_data,
  input  logic              mem_data_valid,
  output logic              wen_data,
  output logic [IW-1:0]     data_word_idx,
  output logic [WORD_W-1:0] data_out,
  output logic              crit_word_ready,
  output logic              wen_tag,
  output logic [TAG_W-1:0]  tag_out,
  output logic              fill_done
);

  localparam int unsigned CNT_W = IW + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    TAG
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [TAG_W-1:0]   tag_q;
  logic [IW-1:0]      start_idx;
  logic [IW-1:0]      crit_idx;
  logic [CNT_W-1:0]   req_cnt;
  logic [CNT_W-1:0]   rsp_cnt;
  logic [OUT_W-1:0]   outstanding;
  logic [IW-1:0]      miss_idx;
  logic [IW-1:0]      req_idx;
  logic [IW-1:0]      rsp_idx;
  logic               miss_take;
  logic               req_fire;
  logic               rsp_fire;

  assign miss_idx = IW'(miss_address >> BO);
  // The line index wraps naturally because the sum is truncated to IW bits.
  assign req_idx  = start_idx + IW'(req_cnt);
  assign rsp_idx  = start_idx + IW'(rsp_cnt);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state and outputs; everything is forced low while rst is high
  always_comb begin
    state_nx        = state;
    fsm_busy        = 1'b0;
    mem_req_valid   = 1'b0;
    mem_address     = '0;
    wen_data        = 1'b0;
    data_word_idx   = '0;
    data_out        = '0;
    crit_word_ready = 1'b0;
    wen_tag         = 1'b0;
    tag_out         = '0;
    fill_done       = 1'b0;
    miss_take       = 1'b0;
    req_fire        = 1'b0;
    rsp_fire        = 1'b0;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          if (miss_detected) begin
            fsm_busy  = 1'b1;
            miss_take = 1'b1;
            state_nx  = FILL;
          end
        end
        FILL: begin
          fsm_busy      = 1'b1;
          mem_req_valid = (req_cnt < CNT_W'(LINE_WORDS)) && (outstanding < OUT_W'(MAX_OUT));
          if (mem_req_valid) begin
            mem_address = (ADDR_W'(tag_q) << OFS) | (ADDR_W'(req_idx) << BO);
          end
          req_fire = mem_req_valid && mem_req_ready;
          // Responses with nothing outstanding are unsolicited and dropped.
          rsp_fire = mem_data_valid && (rsp_cnt < req_cnt);
          if (rsp_fire) begin
            wen_data        = 1'b1;
            data_word_idx   = rsp_idx;
            data_out        = mem_data;
            crit_word_ready = (rsp_idx == crit_idx);
            if (rsp_cnt == CNT_W'(LINE_WORDS - 1)) begin
              state_nx = TAG;
            end
          end
        end
        TAG: begin
          fsm_busy  = 1'b1;
          wen_tag   = 1'b1;
          fill_done = 1'b1;
          tag_out   = tag_q;
          state_nx  = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Miss latch and request/response bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q       <= '0;
      start_idx   <= '0;
      crit_idx    <= '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
    end else if (miss_take) begin
      tag_q       <= TAG_W'(miss_address >> OFS);
      crit_idx    <= miss_idx;
      start_idx   <= (CWF != 0) ? miss_idx : '0;
      req_cnt     <= '0;
      rsp_cnt     <= '0;
      outstanding <= '0;
    end else if (state == FILL) begin
      if (req_fire) begin
        req_cnt <= req_cnt + CNT_W'(1);
      end
      if (rsp_fire) begin
        rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
      // A simultaneous request and response leave the in-flight count unchanged.
      unique case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: a sequential-order instance (u0) and a CWF instance (u1)
// share one memory model; only the selected instance ever sees a miss.
module tb_cache_fill_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        miss_d;
  logic [15:0] miss_address;
  logic        cur_sel;
  logic        mem_req_ready;
  logic [15:0] mem_data;
  logic        mem_data_valid;

  logic        busy0, rv0, wd0, crit0, wt0, fd0;
  logic [15:0] addr0, dout0;
  logic [2:0]  idx0;
  logic [11:0] tag0;
  logic        busy1, rv1, wd1, crit1, wt1, fd1;
  logic [15:0] addr1, dout1;
  logic [2:0]  idx1;
  logic [11:0] tag1;

  cache_fill_ctrl #(.CWF(0)) u0 (
    .clk(clk), .rst(rst),
    .miss_detected(miss_d && !cur_sel), .miss_address(miss_address),
    .fsm_busy(busy0), .mem_req_valid(rv0), .mem_req_ready(mem_req_ready),
    .mem_address(addr0), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .wen_data(wd0), .data_word_idx(idx0), .data_out(dout0),
    .crit_word_ready(crit0), .wen_tag(wt0), .tag_out(tag0), .fill_done(fd0)
  );

  cache_fill_ctrl #(.CWF(1)) u1 (
    .clk(clk), .rst(rst),
    .miss_detected(miss_d && cur_sel), .miss_address(miss_address),
    .fsm_busy(busy1), .mem_req_valid(rv1), .mem_req_ready(mem_req_ready),
    .mem_address(addr1), .mem_data(mem_data), .mem_data_valid(mem_data_valid),
    .wen_data(wd1), .data_word_idx(idx1), .data_out(dout1),
    .crit_word_ready(crit1), .wen_tag(wt1), .tag_out(tag1), .fill_done(fd1)
  );

  logic        o_busy, o_rv, o_wd, o_crit, o_wt, o_fd;
  logic [15:0] o_addr, o_dout;
  logic [2:0]  o_idx;
  logic [11:0] o_tag;
  assign o_busy = cur_sel ? busy1 : busy0;
  assign o_rv   = cur_sel ? rv1   : rv0;
  assign o_wd   = cur_sel ? wd1   : wd0;
  assign o_crit = cur_sel ? crit1 : crit0;
  assign o_wt   = cur_sel ? wt1   : wt0;
  assign o_fd   = cur_sel ? fd1   : fd0;
  assign o_addr = cur_sel ? addr1 : addr0;
  assign o_dout = cur_sel ? dout1 : dout0;
  assign o_idx  = cur_sel ? idx1  : idx0;
  assign o_tag  = cur_sel ? tag1  : tag0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [15:0] exp_req[$];
  logic [2:0]  exp_idx[$];
  logic [15:0] exp_dat[$];
  logic [15:0] pend_addr[$];
  int          pend_due[$];

  logic [11:0] exp_tag;
  logic [2:0]  exp_crit;
  int          exp_crit_pos;
  int lat = 3, rmode = 0, rphase = 0, inject = 0;
  int req_seen, wr_seen, crit_seen, max_o, last_wr_cyc, tag_cyc, miss_cyc;
  int other_act = 0;
  bit done, prev_stalled;
  logic [15:0] prev_addr;
  bit last_busy, last_rv, last_wd, last_wt;

  function automatic logic [15:0] fmem(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: the full expected request/write sequence of one fill.
  task automatic expect_fill(input logic [15:0] a, input bit cwf);
    logic [2:0]  c, st, ix;
    logic [15:0] base, ad;
    base = a & 16'hFFF0;
    c    = a[3:1];
    st   = cwf ? c : 3'd0;
    for (int k = 0; k < 8; k++) begin
      ix = st + 3'(k);
      ad = base | {12'h000, ix, 1'b0};
      exp_req.push_back(ad);
      exp_idx.push_back(ix);
      exp_dat.push_back(fmem(ad));
    end
    exp_tag      = a[15:4];
    exp_crit     = c;
    exp_crit_pos = cwf ? 0 : int'(c);
    req_seen = 0; wr_seen = 0; crit_seen = 0; max_o = 0;
    done = 1'b0; prev_stalled = 1'b0; rphase = 0;
  endtask

  // One clock cycle: drive memory inputs after negedge, observe, advance.
  task automatic cycle();
    mem_req_ready  = (rmode == 0) ? 1'b1 : ((rphase % 3) == 0);
    rphase++;
    mem_data_valid = 1'b0;
    mem_data       = '0;
    if (inject > 0) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
      inject--;
    end else if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = fmem(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
    last_busy = o_busy; last_rv = o_rv; last_wd = o_wd; last_wt = o_wt;
    if (cur_sel ? (wd0 || rv0 || busy0) : (wd1 || rv1 || busy1)) other_act++;
    if (!rst) begin
      if (prev_stalled) begin
        chk("stall_valid", o_rv, 1);
        chk("stall_addr", o_addr, prev_addr);
      end
      if (o_wd) begin
        chk("wr_pending", exp_idx.size() > 0, 1);
        if (exp_idx.size() > 0) begin
          chk("wr_idx", o_idx, exp_idx.pop_front());
          chk("wr_data", o_dout, exp_dat.pop_front());
        end
        if (wr_seen == 0 && rmode == 0 && lat >= 2) chk("reqs_before_first_rsp", req_seen, 2);
        if (o_crit) begin
          crit_seen++;
          chk("crit_idx", o_idx, exp_crit);
          chk("crit_pos", wr_seen, exp_crit_pos);
        end
        wr_seen++;
        last_wr_cyc = cyc;
      end else if (o_crit) begin
        chk("crit_without_wr", o_crit, 0);
      end
      if (o_rv && mem_req_ready) begin
        chk("req_pending", exp_req.size() > 0, 1);
        if (exp_req.size() > 0) chk("req_addr", o_addr, exp_req.pop_front());
        pend_addr.push_back(o_addr);
        pend_due.push_back(cyc + lat);
        req_seen++;
      end
      if (req_seen - wr_seen > max_o) max_o = req_seen - wr_seen;
      prev_stalled = o_rv && !mem_req_ready;
      prev_addr    = o_addr;
      if (o_wt) begin
        chk("tag_out", o_tag, exp_tag);
        chk("fill_done", o_fd, 1);
        chk("tag_busy", o_busy, 1);
        chk("tag_wr_count", wr_seen, 8);
        chk("tag_req_count", req_seen, 8);
        chk("tag_crit_pulses", crit_seen, 1);
        chk("tag_latency", cyc, last_wr_cyc + 1);
        chk("max_outstanding_le2", max_o <= 2, 1);
        tag_cyc = cyc;
        done = 1'b1;
      end else if (o_fd) begin
        chk("fill_done_stray", o_fd, 0);
      end
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_miss(input bit s, input logic [15:0] a);
    cur_sel = s;
    expect_fill(a, s);
    miss_address = a;
    miss_d = 1'b1;
    miss_cyc = cyc;
    cycle();
    chk("miss_cycle_busy", last_busy, 1);
    miss_d = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
    end
    chk({tag, "_completed"}, done, 1);
  endtask

  initial begin
    rst = 1'b1; miss_d = 1'b0; miss_address = '0; cur_sel = 1'b0;
    mem_req_ready = 1'b0; mem_data = '0; mem_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_req_valid", rv0, 0);
    chk("rst_mem_address", addr0, 0);
    chk("rst_wen_data", wd0, 0);
    chk("rst_word_idx", idx0, 0);
    chk("rst_data_out", dout0, 0);
    chk("rst_crit", crit0, 0);
    chk("rst_wen_tag", wt0, 0);
    chk("rst_tag_out", tag0, 0);
    chk("rst_fill_done", fd0, 0);
    chk("rst_busy_cwf", busy1, 0);
    chk("rst_tag_out_cwf", tag1, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) cycle();
    chk("idle_not_busy", last_busy, 0);

    // 1: sequential fill, 3-cycle memory
    lat = 3; rmode = 0;
    do_miss(1'b0, 16'h1234);
    wait_done(100, "t1");
    cycle();
    chk("t1_idle_after_tag", last_busy, 0);

    // 2: critical-word-first with wrap
    do_miss(1'b1, 16'h123A);
    wait_done(100, "t2");
    cycle();

    // 3: overlapped latency
    lat = 6;
    do_miss(1'b0, 16'h2468);
    wait_done(150, "t3");
    chk("t3_max_outstanding", max_o, 2);
    chk("t3_latency_window", ((tag_cyc - miss_cyc) >= 26) && ((tag_cyc - miss_cyc) <= 34), 1);
    cycle();

    // 4: ready toggling 1,0,0
    lat = 3; rmode = 1;
    do_miss(1'b1, 16'h3456);
    wait_done(300, "t4");
    rmode = 0;
    cycle();

    // 5: reset mid-fill, then late responses
    do_miss(1'b0, 16'h5678);
    begin
      int n = 0;
      while (wr_seen < 3 && n < 100) begin cycle(); n++; end
    end
    chk("t5_three_written", wr_seen, 3);
    rst = 1'b1;
    exp_req.delete(); exp_idx.delete(); exp_dat.delete();
    pend_addr.delete(); pend_due.delete();
    cycle();
    rst = 1'b0;
    prev_stalled = 1'b0;
    inject = 2;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t5_late_no_wen_data", last_wd, 0);
      chk("t5_late_no_wen_tag", last_wt, 0);
      chk("t5_late_not_busy", last_busy, 0);
    end
    do_miss(1'b0, 16'h4000);
    wait_done(100, "t5");
    cycle();

    // 6: miss held through TAG; new address latched only in IDLE
    cur_sel = 1'b0;
    expect_fill(16'h1100, 1'b0);
    miss_address = 16'h1100;
    miss_d = 1'b1;
    miss_cyc = cyc;
    cycle();
    chk("t6_miss_busy", last_busy, 1);
    miss_address = 16'h2200;
    wait_done(100, "t6a");
    expect_fill(16'h2200, 1'b0);
    inject = 1;
    cycle();
    chk("t6_idle_no_wen", last_wd, 0);
    chk("t6_idle_busy", last_busy, 1);
    chk("t6_idle_no_req", last_rv, 0);
    chk("t6_idle_cycle", cyc - 1, tag_cyc + 1);
    miss_d = 1'b0;
    cycle();
    chk("t6_fill2_req", last_rv, 1);
    wait_done(100, "t6b");
    repeat (2) cycle();
    chk("final_idle", last_busy, 0);
    chk("other_instance_quiet", other_act, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
